// File: rtl/cp0_excpt_unit_pkg.sv
// ----------------------------------------------------------------------------
// cp0_excpt_unit_pkg
// Shared constants and helpers for the coprocessor-0 exception unit:
//   - CP0 register numbers used by mtc0/mfc0
//   - exception type codes driven on excptype_o
//   - Cause.ExcCode values
//   - Status field layout and its packing into the 32-bit read view
//   - priority encoder for interrupt / syscall / eret
// ----------------------------------------------------------------------------
package cp0_excpt_unit_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // Exception types handed to the exception-control stage
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;

    // Implemented Status bits only; everything else reads as zero
    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // Status read view: IM in 15:8, EXL in 1, IE in 0
    function automatic logic [31:0] status_pack(input status_t st);
        return {16'h0000, st.im, 6'b00_0000, st.exl, st.ie};
    endfunction

    // Cause read view: IP7 in 15, ExcCode in 6:2
    function automatic logic [31:0] cause_pack(input logic ip7, input logic [4:0] exccode);
        return {16'h0000, ip7, 8'h00, exccode, 2'b00};
    endfunction

    // Interrupt first, then syscall, then eret
    function automatic logic [31:0] excpt_prio(input logic int_req,
                                               input logic syscall,
                                               input logic eret);
        logic [31:0] code;
        if (int_req) begin
            code = EXC_TIMER;
        end else if (syscall) begin
            code = EXC_SYSCALL;
        end else if (eret) begin
            code = EXC_ERET;
        end else begin
            code = EXC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/cp0_excpt_unit_timer.sv
// ----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer of coprocessor 0.
//   clk, rst      clock, asynchronous active-high reset
//   count_we      load Count from wdata (wins over the increment)
//   compare_we    load Compare from wdata and clear IP7 (wins over the set)
//   wdata         mtc0 data
//   count         registered Count
//   compare       registered Compare
//   ip7           sticky timer interrupt pending flag (Cause.IP[7])
// Count advances once every COUNT_DIV clocks.
// ----------------------------------------------------------------------------
module cp0_timer
    import cp0_excpt_unit_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);

    localparam logic [7:0] DIV_LAST = 8'(COUNT_DIV - 1);

    logic [7:0]  div_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        ip7_r;
    logic        div_wrap_s;
    logic        match_s;

    // Divider terminal count and Count/Compare match on registered values
    always_comb begin
        div_wrap_s = (div_r == DIV_LAST);
        match_s    = (count_r == compare_r) && (compare_r != 32'h0000_0000);
    end

    // Divider and Count; a Count load also restarts the divider so the next
    // increment lands exactly COUNT_DIV clocks after the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= 8'h00;
            count_r <= 32'h0000_0000;
        end else if (count_we) begin
            div_r   <= 8'h00;
            count_r <= wdata;
        end else if (div_wrap_s) begin
            div_r   <= 8'h00;
            count_r <= count_r + 32'd1;
        end else begin
            div_r   <= div_r + 8'd1;
        end
    end

    // Compare register and sticky IP7; writing Compare acknowledges the timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_r <= 32'h0000_0000;
            ip7_r     <= 1'b0;
        end else if (compare_we) begin
            compare_r <= wdata;
            ip7_r     <= 1'b0;
        end else if (match_s) begin
            ip7_r     <= 1'b1;
        end else begin
            ip7_r     <= ip7_r;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ip7     = ip7_r;

endmodule

// File: rtl/cp0_excpt_unit.sv
// ----------------------------------------------------------------------------
// cp0_excpt_unit
// Coprocessor-0 register file and exception source for the single-cycle CPU.
//   clk, rst      clock, asynchronous active-high reset
//   cp0_we/waddr/wdata   mtc0 write port (effective at the clock edge)
//   cp0_raddr/rdata      mfc0 read port (combinational, no write bypass)
//   pc_i                 PC of the instruction in flight
//   is_syscall/is_eret   decoded instruction class
//   excptype_o           0x4 timer, 0x100 syscall, 0x200 eret, 0 none
//   epc_o                registered EPC
//   timer_int_o          Cause.IP[7]
// ----------------------------------------------------------------------------
module cp0_excpt_unit
    import cp0_excpt_unit_pkg::*;
#(
    parameter int unsigned COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h0001_0001,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] pc_i,
    input  logic        is_syscall,
    input  logic        is_eret,
    output logic [31:0] excptype_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    localparam status_t STATUS_INIT = '{im:  STATUS_RST[15:8],
                                        exl: STATUS_RST[1],
                                        ie:  STATUS_RST[0]};

    status_t     status_r;
    logic [4:0]  exccode_r;
    logic [31:0] epc_r;

    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ip7_s;
    logic        int_req_s;
    logic [31:0] excptype_s;
    logic        wr_ok_s;
    logic        count_we_s;
    logic        compare_we_s;

    // Interrupt request, exception priority and mtc0 qualification; an
    // instruction that traps does not retire, so its mtc0 is dropped
    always_comb begin
        int_req_s    = ip7_s & status_r.im[7] & status_r.ie & ~status_r.exl;
        excptype_s   = excpt_prio(int_req_s, is_syscall, is_eret);
        wr_ok_s      = cp0_we && (excptype_s == EXC_NONE);
        count_we_s   = wr_ok_s && (cp0_waddr == CP0_COUNT);
        compare_we_s = wr_ok_s && (cp0_waddr == CP0_COMPARE);
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wdata      (cp0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ip7        (ip7_s)
    );

    // Status, Cause.ExcCode and EPC: exception entry/return first, then mtc0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r  <= STATUS_INIT;
            exccode_r <= EXCCODE_INT;
            epc_r     <= 32'h0000_0000;
        end else begin
            case (excptype_s)
                EXC_TIMER: begin
                    // interrupted instruction is re-executed on return
                    epc_r        <= pc_i;
                    status_r.exl <= 1'b1;
                    exccode_r    <= EXCCODE_INT;
                end
                EXC_SYSCALL: begin
                    // syscall has completed, resume after it
                    epc_r        <= pc_i + 32'd4;
                    status_r.exl <= 1'b1;
                    exccode_r    <= EXCCODE_SYS;
                end
                EXC_ERET: begin
                    status_r.exl <= 1'b0;
                end
                default: begin
                    if (wr_ok_s) begin
                        case (cp0_waddr)
                            CP0_STATUS: begin
                                status_r.im  <= cp0_wdata[15:8];
                                status_r.exl <= cp0_wdata[1];
                                status_r.ie  <= cp0_wdata[0];
                            end
                            CP0_EPC: begin
                                epc_r <= cp0_wdata;
                            end
                            default: begin
                                // Cause fields are read-only; other numbers unmapped
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // mfc0 read mux; reflects state before any write at the coming edge
    always_comb begin
        case (cp0_raddr)
            CP0_COUNT:   cp0_rdata = count_s;
            CP0_COMPARE: cp0_rdata = compare_s;
            CP0_STATUS:  cp0_rdata = status_pack(status_r);
            CP0_CAUSE:   cp0_rdata = cause_pack(ip7_s, exccode_r);
            CP0_EPC:     cp0_rdata = epc_r;
            CP0_PRID:    cp0_rdata = PRID_VAL;
            default:     cp0_rdata = 32'h0000_0000;
        endcase
    end

    assign excptype_o  = excptype_s;
    assign epc_o       = epc_r;
    assign timer_int_o = ip7_s;

endmodule
